// File: rtl/exec_stage_pkg.sv
// Shared opcode constants for the execute stage and its ALU.
// Shift opcodes are decoded here so every user agrees on which codes are multi-cycle.
package exec_stage_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] ALU_OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_OP_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_OP_SLL = 3'd4;
    localparam logic [OP_W-1:0] ALU_OP_SRL = 3'd5;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
    endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU for the single-cycle opcodes; any other code yields zero.
module exec_stage_alu
    import exec_stage_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_OP_ADD: y_o = a_i + b_i;
            ALU_OP_SUB: y_o = a_i - b_i;
            ALU_OP_AND: y_o = a_i & b_i;
            ALU_OP_OR:  y_o = a_i | b_i;
            default:    y_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus iterative one-bit-per-cycle logical shifts,
// with a valid/ready handshake on both sides and a single output result register.
//
// state | meaning
// IDLE  | ready to accept when the output register is free or being drained
// SHIFT | shifting one bit per cycle; remaining count in cnt_q
module exec_stage
    import exec_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic [TAG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_rd,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                dir_right_q;
    logic [TAG_W-1:0]    shift_rd_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_result_q;
    logic [TAG_W-1:0]    out_rd_q;

    logic [DATA_W-1:0]   alu_y;
    logic [DATA_W-1:0]   shreg_step;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept;
    logic                in_is_shift;
    logic                start_shift;

    exec_stage_alu u_alu (
        .op_i (in_op),
        .a_i  (in_left),
        .b_i  (in_right),
        .y_o  (alu_y)
    );

    assign shamt       = in_right[SHAMT_W-1:0];
    assign in_is_shift = is_shift_op(in_op);
    assign accept      = in_valid && in_ready;
    assign start_shift = accept && in_is_shift && (shamt != '0);
    assign shreg_step  = dir_right_q ? (shreg_q >> 1) : (shreg_q << 1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_shift) state_d = SHIFT;
            SHIFT:   if (cnt_q == SHAMT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
        busy     = (state_q == SHIFT);
    end

    // A held result blocks acceptance via in_ready, so an accept always frees the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            shreg_q      <= '0;
            dir_right_q  <= 1'b0;
            shift_rd_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else if (state_q == SHIFT) begin
            cnt_q   <= cnt_q - SHAMT_W'(1);
            shreg_q <= shreg_step;
            if (cnt_q == SHAMT_W'(1)) begin
                out_valid_q  <= 1'b1;
                out_result_q <= shreg_step;
                out_rd_q     <= shift_rd_q;
            end
        end else if (start_shift) begin
            cnt_q       <= shamt;
            shreg_q     <= in_left;
            dir_right_q <= (in_op == ALU_OP_SRL);
            shift_rd_q  <= in_rd;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_result_q <= in_is_shift ? in_left : alu_y;
            out_rd_q     <= in_rd;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed expectations checked with immediate assertions.
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int errors = 0;
    int checks = 0;

    exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] l,
                         input logic [31:0] r, input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_left  = l;
        in_right = r;
        in_rd    = rd;
        #1;
    endtask

    initial begin
        int stuck;
        logic [31:0] held_res;
        logic [4:0]  held_rd;

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, ALU_OP_ADD, 32'h1111_1111, 32'h2222_2222, 5'd1);
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        rst = 1'b0;
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD wraps modulo 2^32
        drive(1'b1, ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'h0000_0000);
        check("add_rd", {27'd0, out_rd}, 32'd3);

        // back-to-back SUB then AND
        drive(1'b1, ALU_OP_SUB, 32'd5, 32'd7, 5'd4);
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        check("sub_result", out_result, 32'hFFFF_FFFE);
        check("sub_rd", {27'd0, out_rd}, 32'd4);
        drive(1'b1, ALU_OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5);
        check("b2b_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("and_valid", {31'd0, out_valid}, 32'd1);
        check("and_result", out_result, 32'hF000_F000);
        check("and_rd", {27'd0, out_rd}, 32'd5);
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // shift by zero: latency 1, passes in_left
        drive(1'b1, ALU_OP_SLL, 32'h0000_ABCD, 32'h0000_0020, 5'd12);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("sll0_valid", {31'd0, out_valid}, 32'd1);
        check("sll0_result", out_result, 32'h0000_ABCD);
        check("sll0_busy", {31'd0, busy}, 32'd0);

        // SLL 1 by 4 (upper bits of in_right ignored); inputs scrambled after acceptance
        drive(1'b1, ALU_OP_SLL, 32'h0000_0001, 32'h0000_0024, 5'd6);
        tick();
        drive(1'b1, ALU_OP_SRL, 32'hDEAD_BEEF, 32'h0000_0003, 5'd31);
        check("sll_busy_e0", {31'd0, busy}, 32'd1);
        check("sll_ready_e0", {31'd0, in_ready}, 32'd0);
        check("sll_valid_e0", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("sll_busy_mid", {31'd0, busy}, 32'd1);
            check("sll_nvalid_mid", {31'd0, out_valid}, 32'd0);
        end
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("sll_valid", {31'd0, out_valid}, 32'd1);
        check("sll_result", out_result, 32'h0000_0010);
        check("sll_rd", {27'd0, out_rd}, 32'd6);
        check("sll_busy_done", {31'd0, busy}, 32'd0);

        // SRL 0x80000000 by 31, accepted on the edge that consumes the SLL result
        drive(1'b1, ALU_OP_SRL, 32'h8000_0000, 32'd31, 5'd7);
        check("srl_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("srl_valid_e0", {31'd0, out_valid}, 32'd0);
        stuck = 0;
        for (int k = 1; k < 31; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b1) stuck++;
        end
        check("srl_wait_window", stuck, 0);
        tick();
        check("srl_valid", {31'd0, out_valid}, 32'd1);
        check("srl_result", out_result, 32'h0000_0001);
        check("srl_rd", {27'd0, out_rd}, 32'd7);
        tick();
        check("srl_drain", {31'd0, out_valid}, 32'd0);

        // OR result stalled by writeback for 3 cycles, next op pending
        out_ready = 1'b0;
        drive(1'b1, ALU_OP_OR, 32'hA0A0_0000, 32'h0505_0000, 5'd8);
        tick();
        drive(1'b1, ALU_OP_ADD, 32'd2, 32'd3, 5'd9);
        check("or_valid", {31'd0, out_valid}, 32'd1);
        check("or_result", out_result, 32'hA5A5_0000);
        held_res = 32'hA5A5_0000;
        held_rd  = 5'd8;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", out_result, held_res);
            check("stall_rd", {27'd0, out_rd}, {27'd0, held_rd});
            check("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("swap_valid", {31'd0, out_valid}, 32'd1);
        check("swap_result", out_result, 32'd5);
        check("swap_rd", {27'd0, out_rd}, 32'd9);
        tick();
        check("swap_drain", {31'd0, out_valid}, 32'd0);

        // reset two cycles into SLL by 10 aborts it
        drive(1'b1, ALU_OP_SLL, 32'h0000_0003, 32'd10, 5'd10);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        stuck = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) stuck++;
        end
        check("abort_no_result", stuck, 0);

        // undefined opcode yields zero with latency 1
        drive(1'b1, 3'd7, 32'h1234_5678, 32'h0000_0001, 5'd11);
        tick();
        drive(1'b0, ALU_OP_ADD, 32'h0, 32'h0, 5'd0);
        check("op7_valid", {31'd0, out_valid}, 32'd1);
        check("op7_result", out_result, 32'h0000_0000);
        check("op7_rd", {27'd0, out_rd}, 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
